// File: rtl/udp_tx_packetizer.sv
// Ping-pong packet buffer feeding the UDP transmit path: fills one bank from
// the processing stream while the other bank is served word-by-word on request.
module udp_tx_packetizer #(
  parameter int unsigned WORDS_PER_PKT = 256,
  parameter int unsigned GAP_CYCLES    = 64
) (
  input  logic        e_rxc,
  input  logic        reset_n,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        tx_start,
  input  logic        tx_data_req,
  output logic [31:0] tx_data,
  output logic [15:0] tx_data_length,
  output logic [15:0] tx_total_length,
  output logic [15:0] pkt_sent_cnt,
  output logic        underrun
);

  localparam int unsigned AW = (WORDS_PER_PKT > 1) ? $clog2(WORDS_PER_PKT) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS_PER_PKT - 1);

  typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_t;

  state_t        state, state_nxt;
  logic [31:0]   mem [2][WORDS_PER_PKT];
  logic [1:0]    full;
  logic          wr_bank, rd_bank, rd_bank_nxt;
  logic [AW-1:0] wr_addr, rd_addr, rd_addr_nxt;
  logic [GW-1:0] gap_cnt, gap_cnt_nxt;
  logic          wr_en, rd_en, release_bank, req_underrun;

  assign tx_data_length  = 16'(8 + 4 * WORDS_PER_PKT);
  assign tx_total_length = 16'(28 + 4 * WORDS_PER_PKT);

  // Gated by reset_n so the stream sees backpressure while reset is held.
  assign s_ready = reset_n && !full[wr_bank];
  assign wr_en   = s_valid && s_ready;

  always_ff @(posedge e_rxc) begin
    if (wr_en) mem[wr_bank][wr_addr] <= s_data;
  end

  always_comb begin
    state_nxt    = state;
    rd_addr_nxt  = rd_addr;
    rd_bank_nxt  = rd_bank;
    gap_cnt_nxt  = gap_cnt;
    rd_en        = 1'b0;
    release_bank = 1'b0;
    tx_start     = 1'b0;
    unique case (state)
      IDLE: if (full[rd_bank]) state_nxt = START;
      START: begin
        tx_start    = 1'b1;
        rd_addr_nxt = '0;
        state_nxt   = SEND;
      end
      SEND: if (tx_data_req) begin
        rd_en       = 1'b1;
        rd_addr_nxt = rd_addr + 1'b1;
        if (rd_addr == LAST_ADDR) begin
          release_bank = 1'b1;
          rd_addr_nxt  = '0;
          rd_bank_nxt  = ~rd_bank;
          gap_cnt_nxt  = GW'(GAP_CYCLES);
          state_nxt    = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_nxt = IDLE;
        else               gap_cnt_nxt = gap_cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    req_underrun = tx_data_req && (state != SEND);
  end

  always_ff @(posedge e_rxc) begin
    if (!reset_n) begin
      state        <= IDLE;
      full         <= '0;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      wr_addr      <= '0;
      rd_addr      <= '0;
      gap_cnt      <= '0;
      tx_data      <= '0;
      pkt_sent_cnt <= '0;
      underrun     <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_addr <= rd_addr_nxt;
      rd_bank <= rd_bank_nxt;
      gap_cnt <= gap_cnt_nxt;

      if (rd_en)             tx_data <= mem[rd_bank][rd_addr];
      else if (req_underrun) tx_data <= '0;
      if (req_underrun) underrun <= 1'b1;
      if (release_bank) pkt_sent_cnt <= pkt_sent_cnt + 16'd1;

      // Fill and release never target the same bank: a full bank is not writable.
      if (wr_en) begin
        if (wr_addr == LAST_ADDR) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          wr_addr       <= '0;
        end else begin
          wr_addr <= wr_addr + 1'b1;
        end
      end
      if (release_bank) full[rd_bank] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_udp_tx_packetizer.sv
// Scoreboard bench for udp_tx_packetizer: reference model tracks accepted words,
// filled/released packets and expected served words; a monitor checks tx_data.
module tb_udp_tx_packetizer;

  localparam int W  = 256;
  localparam int G  = 64;

  logic        e_rxc = 1'b0;
  logic        reset_n;
  logic [31:0] s_data, s_data_1;
  logic        s_valid, s_valid_1;
  logic        s_ready, s_ready_1;
  logic        tx_start, tx_start_1;
  logic        tx_data_req, tx_data_req_1;
  logic [31:0] tx_data, tx_data_1;
  logic [15:0] tx_data_length, tx_data_length_1;
  logic [15:0] tx_total_length, tx_total_length_1;
  logic [15:0] pkt_sent_cnt, pkt_sent_cnt_1;
  logic        underrun, underrun_1;

  always #5 e_rxc = ~e_rxc;

  udp_tx_packetizer #(.WORDS_PER_PKT(W), .GAP_CYCLES(G)) dut (
    .e_rxc(e_rxc), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .tx_start(tx_start), .tx_data_req(tx_data_req),
    .tx_data(tx_data), .tx_data_length(tx_data_length),
    .tx_total_length(tx_total_length), .pkt_sent_cnt(pkt_sent_cnt),
    .underrun(underrun));

  udp_tx_packetizer #(.WORDS_PER_PKT(1), .GAP_CYCLES(0)) dut1 (
    .e_rxc(e_rxc), .reset_n(reset_n), .s_data(s_data_1), .s_valid(s_valid_1),
    .s_ready(s_ready_1), .tx_start(tx_start_1), .tx_data_req(tx_data_req_1),
    .tx_data(tx_data_1), .tx_data_length(tx_data_length_1),
    .tx_total_length(tx_total_length_1), .pkt_sent_cnt(pkt_sent_cnt_1),
    .underrun(underrun_1));

  int checks = 0;
  int failures = 0;

  logic [31:0] sb[$];
  logic [31:0] acc_q[$];
  int acc_cnt, sent, rel_cnt, left, cyc, last_acc_cyc, last_start_cyc, n_starts;
  bit in_send, start_pending, exp_underrun, rand_mode, mon_en;
  logic req_d, rst_d;
  logic [31:0] last_exp = 32'h0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_ge(input string name, input int got, input int min);
    checks++;
    if (got < min) begin
      failures++;
      $display("FAIL %s: got=%0d expected>=%0d", name, got, min);
    end
  endtask

  task automatic bound(input string name, input bit expired);
    checks++;
    if (expired) begin
      failures++;
      $display("FAIL %s: got=bound expired expected=event within bound", name);
    end
  endtask

  function automatic int buffered();
    return acc_cnt / W - rel_cnt;
  endfunction

  task automatic model_reset();
    acc_q.delete(); sb.delete();
    acc_cnt = 0; sent = 0; rel_cnt = 0; left = 0; n_starts = 0;
    in_send = 0; start_pending = 0; exp_underrun = 0;
  endtask

  // One clock of stimulus: checks status outputs against the model, then drives.
  task automatic cycle(input bit v, input bit r, input bit force_r);
    bit rq;
    @(negedge e_rxc);
    cyc++;
    check("s_ready", s_ready, buffered() < 2);
    check("pkt_sent_cnt", pkt_sent_cnt, 16'(rel_cnt));
    check("underrun", underrun, exp_underrun);
    if (start_pending) begin
      in_send = 1; left = W; start_pending = 0;
    end
    if (in_send || buffered() < 1) begin
      check("tx_start_unexpected", tx_start, 0);
    end else if (tx_start) begin
      if (n_starts > 0) check_ge("tx_start_spacing", cyc - last_start_cyc, G + 2);
      n_starts++; last_start_cyc = cyc; start_pending = 1;
    end
    s_valid = v;
    s_data  = rand_mode ? $urandom : 32'(acc_cnt);
    if (v && s_ready) begin
      acc_q.push_back(s_data); acc_cnt++; last_acc_cyc = cyc;
    end
    rq = force_r || (r && in_send);
    tx_data_req = rq;
    if (rq) begin
      if (in_send) begin
        sb.push_back(acc_q[sent]); sent++; left--;
        if (left == 0) begin in_send = 0; rel_cnt++; end
      end else begin
        sb.push_back(32'h0); exp_underrun = 1;
      end
    end
  endtask

  always @(posedge e_rxc) begin
    req_d <= tx_data_req;
    rst_d <= !reset_n;
  end

  always @(negedge e_rxc) begin
    if (mon_en) begin
      if (rst_d) begin
        last_exp = 32'h0;
        check("tx_data_reset", tx_data, 32'h0);
      end else if (req_d) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL scoreboard_empty: got=unexpected word 0x%0h expected=none", tx_data);
        end else begin
          last_exp = sb.pop_front();
          check("tx_data", tx_data, last_exp);
        end
      end else begin
        check("tx_data_hold", tx_data, last_exp);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=simulation still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g;
    int tgt;
    logic [31:0] w;
    reset_n = 0; s_valid = 0; s_data = '0; tx_data_req = 0;
    s_valid_1 = 0; s_data_1 = '0; tx_data_req_1 = 0;
    model_reset(); rand_mode = 0; mon_en = 0; cyc = 0;
    repeat (3) @(negedge e_rxc);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_pkt_cnt", pkt_sent_cnt, 0);
    check("rst_underrun", underrun, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_tx_data_1", tx_data_1, 0);
    check("udp_len", tx_data_length, 16'd1032);
    check("ip_len", tx_total_length, 16'd1052);
    mon_en = 1;
    reset_n = 1;

    // Single packet of index data, full rate, latency and content.
    repeat (W) cycle(1, 0, 0);
    check("t1_all_accepted", acc_cnt, W);
    g = 0;
    while (!start_pending && g < 10) begin cycle(0, 0, 0); g++; end
    bound("t1_wait_start", !start_pending);
    check("t1_start_latency", last_start_cyc, last_acc_cyc + 2);
    g = 0;
    while (rel_cnt < 1 && g < 1000) begin cycle(0, 1, 0); g++; end
    bound("t1_serve", rel_cnt < 1);
    cycle(0, 0, 0);

    // Both banks full without requests: backpressure, then drain in order.
    repeat (900) cycle(acc_cnt < 4 * W, 0, 0);
    check("t2_backpressure_accepted", acc_cnt, 3 * W);
    g = 0;
    while (rel_cnt < 4 && g < 6000) begin cycle(acc_cnt < 4 * W, 1, 0); g++; end
    bound("t2_drain", rel_cnt < 4);
    repeat (G + 10) cycle(0, 0, 0);

    // Random input and request pacing over four packets.
    rand_mode = 1;
    tgt = acc_cnt + 4 * W;
    g = 0;
    while (rel_cnt < tgt / W && g < 20000) begin
      cycle(acc_cnt < tgt && $urandom_range(3) != 0, $urandom_range(3) != 0, 0);
      g++;
    end
    bound("t3_random", rel_cnt < tgt / W);
    repeat (G + 10) cycle(0, 0, 0);

    // Request landing in GAP right after the last word.
    tgt = acc_cnt + W;
    g = 0;
    while (rel_cnt < tgt / W && g < 2000) begin cycle(acc_cnt < tgt, 1, 0); g++; end
    bound("t4_serve", rel_cnt < tgt / W);
    cycle(0, 0, 1);
    repeat (G + 10) cycle(0, 0, 0);

    // Reset after 100 words of a packet have been served.
    rand_mode = 0;
    tgt = acc_cnt + W;
    g = 0;
    while (!(in_send && left == W - 100) && g < 2000) begin
      cycle(acc_cnt < tgt, 1, 0); g++;
    end
    bound("t5_partial", !(in_send && left == W - 100));
    cycle(0, 0, 0);
    @(negedge e_rxc);
    reset_n = 0; s_valid = 0; tx_data_req = 0;
    #1 check("t5_s_ready_in_reset", s_ready, 0);
    @(negedge e_rxc);
    check("t5_tx_start", tx_start, 0);
    check("t5_pkt_cnt", pkt_sent_cnt, 0);
    check("t5_underrun", underrun, 0);
    check("t5_s_ready", s_ready, 0);
    model_reset();
    reset_n = 1;
    repeat (300) cycle(0, 0, 0);
    g = 0;
    while (rel_cnt < 1 && g < 2000) begin cycle(acc_cnt < W, 1, 0); g++; end
    bound("t5_new_stream", rel_cnt < 1);
    repeat (5) cycle(0, 0, 0);

    // Single-word packets with no gap on the second instance.
    check("w1_udp_len", tx_data_length_1, 16'd12);
    check("w1_ip_len", tx_total_length_1, 16'd32);
    for (int k = 0; k < 4; k++) begin
      @(negedge e_rxc);
      w = $urandom;
      check("w1_s_ready", s_ready_1, 1);
      s_data_1 = w; s_valid_1 = 1;
      @(negedge e_rxc);
      s_valid_1 = 0;
      check("w1_tx_start_early", tx_start_1, 0);
      @(negedge e_rxc);
      check("w1_tx_start", tx_start_1, 1);
      @(negedge e_rxc);
      tx_data_req_1 = 1;
      @(negedge e_rxc);
      tx_data_req_1 = 0;
      check("w1_tx_data", tx_data_1, w);
      check("w1_pkt_cnt", pkt_sent_cnt_1, 16'(k + 1));
    end
    check("w1_underrun", underrun_1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
